// File: rtl/cnn_pkg.sv
// cnn_pkg: FSM state type and default widths shared by the bias fill engine files
package cnn_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int BURST_DEF  = 25;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_WRITE, S_DONE} state_e;
endpackage

// File: rtl/bias_fill_addr_gen.sv
// bias_fill_addr_gen: group/channel/pixel counters producing load and write addresses
module bias_fill_addr_gen
    import cnn_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BURST  = BURST_DEF,
    parameter int SW     = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_step,
    input  logic              wr_step,
    input  logic [ADDR_W-1:0] bias_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [ADDR_W-1:0] nob,
    input  logic [ADDR_W-1:0] pix,
    output logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] write_addr,
    output logic [SW-1:0]     slot,
    output logic              grp_end,
    output logic              all_end
);
    logic [ADDR_W-1:0] goff_q, goff_d, k_q, k_d, p_q, p_d, c_q, c_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic              last_pix, last_chan, last_slot;

    assign last_pix   = p_q == pix - 1'b1;
    assign last_chan  = c_q == nob - 1'b1;
    assign last_slot  = slot_q == SW'(BURST - 1);
    assign grp_end    = last_pix && (last_slot || last_chan);
    assign all_end    = last_pix && last_chan;
    assign load_addr  = bias_base + goff_q;
    assign write_addr = out_base + k_q;
    assign slot       = slot_q;

    // Writes are contiguous across channels, so one running offset k gives every write address
    always_comb begin
        goff_d = goff_q;
        k_d    = k_q;
        p_d    = p_q;
        c_d    = c_q;
        slot_d = slot_q;
        if (start) begin
            goff_d = '0;
            k_d    = '0;
            p_d    = '0;
            c_d    = '0;
            slot_d = '0;
        end else begin
            if (load_step) goff_d = goff_q + ADDR_W'(BURST);
            if (wr_step) begin
                k_d    = k_q + 1'b1;
                p_d    = last_pix ? '0 : p_q + 1'b1;
                c_d    = last_pix ? c_q + 1'b1 : c_q;
                slot_d = last_pix ? (last_slot ? '0 : slot_q + 1'b1) : slot_q;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            goff_q <= '0;
            k_q    <= '0;
            p_q    <= '0;
            c_q    <= '0;
            slot_q <= '0;
        end else begin
            goff_q <= goff_d;
            k_q    <= k_d;
            p_q    <= p_d;
            c_q    <= c_d;
            slot_q <= slot_d;
        end
    end
endmodule

// File: rtl/bias_fill_engine.sv
// bias_fill_engine: loads bias bursts and fills output planes; BIAS_FILL_ERR_EN adds an address-overflow flag
module bias_fill_engine
    import cnn_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BURST    = BURST_DEF,
    parameter int LOAD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [ADDR_W-1:0]          biasAddress,
    input  logic [ADDR_W-1:0]          numberOfBiases,
    input  logic [ADDR_W-1:0]          outImgAddress,
    input  logic [ADDR_W-1:0]          outImgSize,
    input  logic signed [BURST*DATA_W-1:0] loadedBiases,
    input  logic                       writeReady,
    output logic [ADDR_W-1:0]          loadAddr,
    output logic                       loadEnable,
    output logic signed [DATA_W-1:0]   writeBias,
    output logic [ADDR_W-1:0]          writeAddr,
    output logic                       writeEnable,
    output logic                       done
`ifdef BIAS_FILL_ERR_EN
    ,
    output logic                       error
`endif
);
    localparam int SW = (BURST > 1) ? $clog2(BURST) : 1;

    state_e                   state_q, state_d;
    logic [2:0]               wait_q, wait_d;
    logic [ADDR_W-1:0]        bias_q, nob_q, out_q, size_q, pix, load_addr, write_addr;
    logic signed [DATA_W-1:0] buf_q [BURST];
    logic [SW-1:0]            slot;
    logic                     start, load_step, wr_step, cap, grp_end, all_end;

    assign pix         = size_q * size_q;
    assign loadAddr    = loadEnable ? load_addr : '0;
    assign writeAddr   = writeEnable ? write_addr : '0;
    assign writeBias   = writeEnable ? buf_q[slot] : '0;

    bias_fill_addr_gen #(.ADDR_W(ADDR_W), .BURST(BURST), .SW(SW)) u_addr (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_step  (load_step),
        .wr_step    (wr_step),
        .bias_base  (bias_q),
        .out_base   (out_q),
        .nob        (nob_q),
        .pix        (pix),
        .load_addr  (load_addr),
        .write_addr (write_addr),
        .slot       (slot),
        .grp_end    (grp_end),
        .all_end    (all_end)
    );

    // Next state and per-state strobes; outputs decode from the registered state only
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        start       = 1'b0;
        load_step   = 1'b0;
        wr_step     = 1'b0;
        cap         = 1'b0;
        loadEnable  = 1'b0;
        writeEnable = 1'b0;
        done        = 1'b0;
        case (state_q)
            S_IDLE: if (enable) begin
                start   = 1'b1;
                state_d = (numberOfBiases == '0 || outImgSize == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                loadEnable = 1'b1;
                load_step  = 1'b1;
                wait_d     = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_d = wait_q + 1'b1;
                if (wait_q == 3'(LOAD_LAT - 1)) begin
                    cap     = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                writeEnable = 1'b1;
                if (writeReady) begin
                    wr_step = 1'b1;
                    state_d = all_end ? S_DONE : grp_end ? S_LOAD : S_WRITE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset abandons any job in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Job configuration frozen as the FSM leaves IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bias_q <= '0;
            nob_q  <= '0;
            out_q  <= '0;
            size_q <= '0;
        end else if (start) begin
            bias_q <= biasAddress;
            nob_q  <= numberOfBiases;
            out_q  <= outImgAddress;
            size_q <= outImgSize;
        end
    end

    // Burst buffer captured on the last WAIT cycle
    always_ff @(posedge clk) begin
        if (cap) for (int i = 0; i < BURST; i++) buf_q[i] <= loadedBiases[i*DATA_W +: DATA_W];
    end

`ifdef BIAS_FILL_ERR_EN
    localparam int EW = 2 * ADDR_W + 1;
    localparam logic [EW-1:0] LIM = {{ADDR_W{1'b0}}, 1'b1, {ADDR_W{1'b0}}};
    logic [EW-1:0] span;
    logic          err_q;
    assign span  = EW'(out_q) + EW'(nob_q) * EW'(pix);
    assign error = err_q;

    // Overflow flag: cleared on start, evaluated on arrival in DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else if (start) err_q <= 1'b0;
        else if (state_d == S_DONE && state_q != S_DONE) err_q <= span > LIM;
    end
`endif
endmodule

// File: tb/tb_bias_fill_engine.sv
// tb_bias_fill_engine: directed jobs checked against a queue-based model of the fill sequence
module tb_bias_fill_engine;
    localparam int DW = 16, AW = 16, BU = 25, LAT = 1;

    logic clk = 0, reset = 0, enable = 0, writeReady = 1;
    logic [AW-1:0] biasAddress = 0, numberOfBiases = 0, outImgAddress = 0, outImgSize = 0;
    logic signed [BU*DW-1:0] loadedBiases = '0;
    logic [AW-1:0] loadAddr, writeAddr;
    logic signed [DW-1:0] writeBias;
    logic loadEnable, writeEnable, done;
`ifdef BIAS_FILL_ERR_EN
    logic error;
`endif

    always #5 clk = ~clk;

    bias_fill_engine #(.DATA_W(DW), .ADDR_W(AW), .BURST(BU), .LOAD_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .biasAddress(biasAddress), .numberOfBiases(numberOfBiases),
        .outImgAddress(outImgAddress), .outImgSize(outImgSize),
        .loadedBiases(loadedBiases), .writeReady(writeReady),
        .loadAddr(loadAddr), .loadEnable(loadEnable),
        .writeBias(writeBias), .writeAddr(writeAddr), .writeEnable(writeEnable),
        .done(done)
`ifdef BIAS_FILL_ERR_EN
        , .error(error)
`endif
    );

    int checks = 0, failures = 0;
    int cyc = 0, load_cyc = 0, nwr = 0, nld = 0, we_cycles = 0;
    logic wait_first = 0, stall_v = 0;
    logic [AW-1:0] stall_a, first_a, last_a, last_la;
    logic [DW-1:0] stall_b, first_b, last_b;
    logic [AW-1:0] exp_la[$];
    logic [AW+DW-1:0] exp_w[$];

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return DW'(int'(a) * 37 + 5);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Model: bias c is memory word biasAddress+c, written to outImgAddress+c*pix+p in order
    task automatic expect_job(input logic [AW-1:0] b, input logic [AW-1:0] n,
                              input logic [AW-1:0] o, input logic [AW-1:0] s);
        logic [AW-1:0] pl;
        int pix;
        pl = s * s;
        pix = int'(pl);
        exp_la.delete();
        exp_w.delete();
        if (n == 0 || s == 0) return;
        for (int g = 0; g * BU < int'(n); g++) exp_la.push_back(AW'(int'(b) + g * BU));
        for (int c = 0; c < int'(n); c++)
            for (int p = 0; p < pix; p++)
                exp_w.push_back({AW'(int'(o) + c * pix + p), mem(AW'(int'(b) + c))});
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: burst data valid only in the cycle after the request, junk otherwise
    always @(posedge clk) begin
        if (loadEnable) for (int i = 0; i < BU; i++) loadedBiases[i*DW +: DW] <= mem(loadAddr + AW'(i));
        else loadedBiases <= '1;
    end

    // Compare process
    always @(negedge clk) begin
        if (!reset) stall_v = 0;
        else begin
            if (loadEnable && writeEnable) check("ld_wr_overlap", 1, 0);
            if (stall_v) check("stall_hold", {writeEnable, writeAddr, writeBias}, {1'b1, stall_a, stall_b});
            if (loadEnable) begin
                nld++;
                last_la = loadAddr;
                if (exp_la.size() == 0) check("unexpected_load", 1, 0);
                else check("load_addr", loadAddr, exp_la.pop_front());
                load_cyc = cyc;
                wait_first = 1;
            end
            if (writeEnable) begin
                we_cycles++;
                if (wait_first) check("first_write_latency", cyc - load_cyc, LAT + 1);
                wait_first = 0;
            end
            if (writeEnable && writeReady) begin
                if (nwr == 0) begin first_a = writeAddr; first_b = writeBias; end
                last_a = writeAddr;
                last_b = writeBias;
                nwr++;
                if (exp_w.size() == 0) check("unexpected_write", 1, 0);
                else check("write", {writeAddr, writeBias}, exp_w.pop_front());
            end
            stall_v = writeEnable && !writeReady;
            stall_a = writeAddr;
            stall_b = writeBias;
        end
    end

    task automatic run_job(input logic [AW-1:0] b, input logic [AW-1:0] n, input logic [AW-1:0] o,
                           input logic [AW-1:0] s, input bit tog, output int k);
        expect_job(b, n, o, s);
        nwr = 0; nld = 0; we_cycles = 0;
        biasAddress = b; numberOfBiases = n; outImgAddress = o; outImgSize = s;
        writeReady = 1;
        enable = 1;
        tick;
        biasAddress = ~b; numberOfBiases = n + 7; outImgAddress = o + 3; outImgSize = s + 1;
        k = 0;
        while (!done && k < 5000) begin
            if (tog) writeReady = ~writeReady;
            tick;
            k++;
        end
        check("job_done", done, 1);
        check("model_drained", exp_w.size() + exp_la.size(), 0);
        tick;
        check("done_held", done, 1);
        enable = 0;
        writeReady = 1;
        tick;
        check("done_cleared", done, 0);
    endtask

    initial begin
        int k;
        repeat (3) tick;
        check("reset_outputs", {loadEnable, writeEnable, done, loadAddr, writeAddr, writeBias}, 0);
        reset = 1;
        tick;
        check("idle_outputs", {loadEnable, writeEnable, done}, 0);

        run_job(0, 50, 150, 2, 0, k);
        check("r32_loads", nld, 2);
        check("r32_second_load", last_la, 25);
        check("r32_writes", nwr, 200);
        check("r32_first", {first_a, first_b}, {16'd150, 16'd5});
        check("r32_last", {last_a, last_b}, {16'd349, 16'd1818});
`ifdef BIAS_FILL_ERR_EN
        check("r32_no_err", error, 0);
`endif

        run_job(100, 3, 1000, 3, 0, k);
        check("r33_loads", nld, 1);
        check("r33_writes", nwr, 27);
        check("r33_we_cycles", we_cycles, 27);
        check("r33_first", {first_a, first_b}, {16'd1000, 16'd3705});
        check("r33_last", {last_a, last_b}, {16'd1026, 16'd3779});

        run_job(100, 3, 1000, 3, 1, k);
        check("r34_writes", nwr, 27);
        check("r34_duration", (we_cycles == 53 || we_cycles == 54), 1);

        run_job(10, 0, 40, 4, 0, k);
        check("r35_nob0_latency", k <= 1, 1);
        check("r35_nob0_quiet", {nld[7:0], we_cycles[7:0]}, 0);
        run_job(10, 4, 40, 0, 0, k);
        check("r35_size0_latency", k <= 1, 1);
        check("r35_size0_quiet", {nld[7:0], we_cycles[7:0]}, 0);

        expect_job(0, 50, 150, 2);
        nwr = 0;
        biasAddress = 0; numberOfBiases = 50; outImgAddress = 150; outImgSize = 2;
        enable = 1;
        for (int i = 0; i < 500 && nwr < 10; i++) tick;
        check("r36_progress", nwr >= 10, 1);
        #2 reset = 0;
        #1 check("r36_reset_outputs", {loadEnable, writeEnable, done, loadAddr, writeAddr, writeBias}, 0);
        exp_la.delete();
        exp_w.delete();
        enable = 0;
        repeat (2) tick;
        reset = 1;
        tick;
        check("r36_idle_after", {loadEnable, writeEnable, done}, 0);
        run_job(7, 2, 500, 1, 0, k);
        check("r36_restart_load", {nld[7:0], last_la}, {8'd1, 16'd7});
        check("r36_restart_first", {first_a, first_b}, {16'd500, 16'd264});

`ifdef BIAS_FILL_ERR_EN
        run_job(0, 10, 65500, 4, 0, k);
        check("r37_wrap_first", first_a, 16'd65500);
        check("r37_wrap_last", last_a, 16'd123);
        check("r37_error", error, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bias_fill_engine.md
BIAS_FILL_ENGINE -- requirements
Module: bias_fill_engine

Interface
REQ-001 SHALL have parameter DATA_W, 16, bias/data word width.
REQ-002 SHALL have parameter ADDR_W, 16, memory address and count width.
REQ-003 SHALL have parameter BURST, 25, words returned per memory load.
REQ-004 SHALL have parameter LOAD_LAT, 1, cycles from loadEnable to valid loadedBiases (range 1..4).
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, start request, level-sampled in IDLE.
REQ-008 SHALL have ports biasAddress, numberOfBiases, outImgAddress, outImgSize, input, ADDR_W each: bias base, channel count, output base, output side length.
REQ-009 SHALL have port loadedBiases, input, BURST x DATA_W signed: memory burst read data.
REQ-010 SHALL have ports loadAddr (ADDR_W) and loadEnable (1), output: burst read request.
REQ-011 SHALL have port writeReady, input, 1: memory accepts write this cycle.
REQ-012 SHALL have ports writeBias (DATA_W signed), writeAddr (ADDR_W), writeEnable (1), output: write request.
REQ-013 SHALL have port done, output, 1: job complete.

Function
REQ-014 SHALL latch all four configuration inputs when leaving IDLE; later input changes have no effect until next job.
REQ-015 SHALL use FSM states IDLE, LOAD, WAIT, WRITE, DONE.
REQ-016 IDLE -> LOAD when enable=1 and numberOfBiases>0 and outImgSize>0; IDLE -> DONE when enable=1 and either is 0 (no loads, no writes).
REQ-017 LOAD SHALL assert loadEnable for exactly one cycle with loadAddr = biasAddress + g*BURST (group g), then enter WAIT.
REQ-018 WAIT SHALL last LOAD_LAT cycles, capture loadedBiases into an internal BURST-entry buffer on its last cycle, then enter WRITE.
REQ-019 WRITE SHALL present, per channel c, pix = outImgSize*outImgSize writes of bias c to addresses outImgAddress + c*pix + p, p = 0..pix-1, ascending.
REQ-020 A write SHALL complete only in a cycle with writeEnable=1 and writeReady=1; while writeReady=0, writeEnable, writeAddr, writeBias SHALL hold stable.
REQ-021 After the last buffered channel of a group: LOAD for the next group if channels remain, else DONE.
REQ-022 Final group SHALL consume only numberOfBiases - g*BURST buffer entries; remaining entries ignored.
REQ-023 pix and all address sums SHALL be computed modulo 2^ADDR_W (wrap, no error).
REQ-024 loadEnable and writeEnable SHALL never be high in the same cycle.
REQ-025 DONE SHALL hold done=1 until enable=0, then return to IDLE; done is 0 in all other states.
REQ-026 First write SHALL appear in the cycle after WAIT completes; sustained throughput one write per cycle with writeReady=1.

Reset
REQ-027 reset=0 SHALL immediately force IDLE and drive loadEnable, writeEnable, done, loadAddr, writeAddr, writeBias to 0, including mid-job; no resumption after release.

Configuration
REQ-028 Macro BIAS_FILL_ERR_EN SHALL, when defined, add output error (1 bit, reset 0) set in DONE when outImgAddress + numberOfBiases*pix exceeded 2^ADDR_W, cleared on next start; writes still wrap per REQ-023.
REQ-029 Without BIAS_FILL_ERR_EN, port error and overflow logic SHALL be absent.

Structure
REQ-030 Package cnn_pkg SHALL hold the FSM state enum and default DATA_W/ADDR_W/BURST constants.
REQ-031 Address/count generation SHALL be sub-module bias_fill_addr_gen (channel, pixel, group counters and address outputs); FSM and buffer stay in bias_fill_engine.

Verification
REQ-032 numberOfBiases=50, outImgSize=2, outImgAddress=150, biasAddress=0, writeReady=1 -> loads at 0 and 25, 200 writes to 150..349, bias c at 150+4c..153+4c, done.
REQ-033 numberOfBiases=3, outImgSize=3 -> one load, 27 writes, group tail entries 3..24 never written.
REQ-034 writeReady toggled 0/1 every cycle -> identical write sequence, outputs stable while stalled, 2x write duration.
REQ-035 numberOfBiases=0 or outImgSize=0 -> no loadEnable, no writeEnable, done within 2 cycles of enable.
REQ-036 reset=0 asserted mid-WRITE -> all outputs 0 same cycle; new job after release starts at group 0.
REQ-037 BIAS_FILL_ERR_EN defined, outImgAddress=65500, numberOfBiases=10, outImgSize=4 -> addresses wrap past 65535, error=1 at done.
